// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the frame interrupt controller.
// Holds the controller FSM state encoding and the bit positions inside irq_cause.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int CAUSE_FRAME = 0;
  localparam int CAUSE_JUMP  = 1;
  localparam int CAUSE_W     = 2;

endpackage

// File: rtl/frame_irq_controller_jump_conditioner.sv
// Conditions the raw jump button: two-flop synchronizer, optional debounce
// (enabled by defining JUMP_DEBOUNCE_EN), and a one-cycle rising-edge pulse.
module jump_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic jump,
  output logic jump_rise
);

  logic sync_1;
  logic sync_2;
  logic level;
  logic level_q;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= jump;
      sync_2 <= sync_1;
    end
  end

`ifdef JUMP_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [DB_W-1:0] db_cnt;
  logic            db_level;

  // Accept a new level only after the synced input differed for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync_2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_level <= sync_2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = db_level;
`else
  assign level = sync_2;
`endif

  // Remember the previous conditioned level so a rising edge can be detected
  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign jump_rise = level & ~level_q;

endmodule

// File: rtl/frame_irq_controller.sv
// Per-frame game loop sequencer: divides the clock into frame ticks, collects
// jump presses and runs the IRQ / ack / frame_done handshake with the CPU.
// Optional jump debounce is selected with the JUMP_DEBOUNCE_EN macro.
module frame_irq_controller
  import game_ctrl_pkg::*;
#(
  parameter int SYS_FREQ        = 100000000,
  parameter int FRAME_RATE      = 60,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FCNT_W          = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               jump,
  output logic               irq,
  output logic [CAUSE_W-1:0] irq_cause,
  input  logic               irq_ack,
  input  logic               frame_done,
  output logic [FCNT_W-1:0]  frame_count,
  output logic               overrun,
  input  logic               overrun_clr
);

  localparam int PERIOD = SYS_FREQ / FRAME_RATE;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0]   tick_cnt;
  logic               tick;
  logic               jump_rise;
  logic               tick_pend;
  logic               jump_pend;
  logic               ack_taken;
  logic               clr_tick;
  logic               clr_jump;
  logic [CAUSE_W-1:0] new_cause;
  state_t             state;

  jump_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_jump_conditioner (
    .clock    (clock),
    .reset    (reset),
    .jump     (jump),
    .jump_rise(jump_rise)
  );

  assign tick      = (tick_cnt == CNT_W'(PERIOD - 1));
  assign ack_taken = (state == ST_REQ) && irq_ack;
  assign clr_tick  = ack_taken && irq_cause[CAUSE_FRAME];
  assign clr_jump  = ack_taken && irq_cause[CAUSE_JUMP];

  // Snapshot of the pending events that the next request will report
  always_comb begin
    new_cause              = '0;
    new_cause[CAUSE_FRAME] = tick_pend;
    new_cause[CAUSE_JUMP]  = jump_pend;
  end

  // Free-running frame divider, tick on the last count of each period
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Pending flags: a fresh event beats the ack clear; a second tick flags overrun
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_pend <= 1'b0;
      jump_pend <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (tick) begin
        tick_pend <= 1'b1;
      end else if (clr_tick) begin
        tick_pend <= 1'b0;
      end
      if (jump_rise) begin
        jump_pend <= 1'b1;
      end else if (clr_jump) begin
        jump_pend <= 1'b0;
      end
      if (tick && tick_pend) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  // Handshake FSM with registered irq, irq_cause and frame counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      irq         <= 1'b0;
      irq_cause   <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick_pend || jump_pend) begin
            state     <= ST_REQ;
            irq       <= 1'b1;
            irq_cause <= new_cause;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state     <= ST_RUN;
            irq       <= 1'b0;
            irq_cause <= '0;
            if (irq_cause[CAUSE_FRAME]) begin
              frame_count <= frame_count + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (frame_done) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          irq       <= 1'b0;
          irq_cause <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_irq_controller.sv
// Directed bench for frame_irq_controller with PERIOD=10 and DEBOUNCE_CYCLES=4.
// Expected jump timing follows JUMP_DEBOUNCE_EN when the macro is defined.
module tb_frame_irq_controller;

  logic        clock;
  logic        reset;
  logic        jump;
  logic        irq;
  logic [1:0]  irq_cause;
  logic        irq_ack;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        overrun;
  logic        overrun_clr;

  int compared;
  int mismatched;
  int cyc;
  int jump_events;
  int ev_base;

`ifdef JUMP_DEBOUNCE_EN
  localparam int JD        = 4;
  localparam int GLITCH_EV = 0;
`else
  localparam int JD        = 0;
  localparam int GLITCH_EV = 1;
`endif

  frame_irq_controller #(
    .SYS_FREQ       (100),
    .FRAME_RATE     (10),
    .DEBOUNCE_CYCLES(4),
    .FCNT_W         (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .jump       (jump),
    .irq        (irq),
    .irq_cause  (irq_cause),
    .irq_ack    (irq_ack),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  // 10-unit clock period
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle index since reset release: after edge n, cyc == n
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Count conditioned jump edges seen by the controller
  always @(posedge clock) begin
    if (dut.jump_rise) jump_events <= jump_events + 1;
  end

  // Hard stop in case the schedule ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic ack, input logic done, input logic clr, input logic jmp);
    irq_ack     = ack;
    frame_done  = done;
    overrun_clr = clr;
    jump        = jmp;
  endtask

  // Advance to the negative edge following rising edge n
  task automatic go_to(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("schedule", 32'(cyc), 32'(n));
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    jump_events = 0;
    reset       = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);

    checkOutput("rst_irq",     32'(irq), 32'd0);
    checkOutput("rst_cause",   32'(irq_cause), 32'd0);
    checkOutput("rst_fcount",  32'(frame_count), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_tickcnt", 32'(dut.tick_cnt), 32'd0);
    reset = 1'b0;

    // First tick: pend at edge 10, irq at edge 11, held until ack
    go_to(10);
    checkOutput("t1_irq_low",   32'(irq), 32'd0);
    checkOutput("t1_tick_pend", 32'(dut.tick_pend), 32'd1);
    go_to(11);
    checkOutput("t1_irq",   32'(irq), 32'd1);
    checkOutput("t1_cause", 32'(irq_cause), 32'd1);
    go_to(14);
    checkOutput("t1_irq_held", 32'(irq), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    go_to(15);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_ack_irq",   32'(irq), 32'd0);
    checkOutput("t1_ack_cause", 32'(irq_cause), 32'd0);
    checkOutput("t1_fcount",    32'(frame_count), 32'd1);

    // RUN until frame_done three cycles later, next frame irq at edge 21
    go_to(17);
    checkOutput("t2_run_irq", 32'(irq), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    go_to(18);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    go_to(20);
    checkOutput("t2_irq_low", 32'(irq), 32'd0);
    go_to(21);
    checkOutput("t2_irq",   32'(irq), 32'd1);
    checkOutput("t2_cause", 32'(irq_cause), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    go_to(22);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_fcount", 32'(frame_count), 32'd2);
    go_to(23);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Jump edge and tick land in the same cycle: one irq with both causes
    go_to(27 - JD);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    go_to(30);
    checkOutput("t3_jump_pend", 32'(dut.jump_pend), 32'd1);
    checkOutput("t3_tick_pend", 32'(dut.tick_pend), 32'd1);
    go_to(31);
    checkOutput("t3_irq",   32'(irq), 32'd1);
    checkOutput("t3_cause", 32'(irq_cause), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    go_to(32);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_fcount",     32'(frame_count), 32'd3);
    checkOutput("t3_tick_clear", 32'(dut.tick_pend), 32'd0);
    checkOutput("t3_jump_clear", 32'(dut.jump_pend), 32'd0);
    go_to(33);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Jump during RUN waits for frame_done, then jump-only irq
    go_to(41);
    checkOutput("t4_irq",   32'(irq), 32'd1);
    checkOutput("t4_cause", 32'(irq_cause), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    go_to(42);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_fcount", 32'(frame_count), 32'd4);
    go_to(48);
    checkOutput("t4_run_irq", 32'(irq), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    go_to(49);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_idle_irq", 32'(irq), 32'd0);
    go_to(50);
    checkOutput("t4_jump_irq",   32'(irq), 32'd1);
    checkOutput("t4_jump_cause", 32'(irq_cause), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    go_to(51);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_fcount_same", 32'(frame_count), 32'd4);
    checkOutput("t4_tick_kept",   32'(dut.tick_pend), 32'd1);
    go_to(52);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    go_to(53);
    checkOutput("t4_next_cause", 32'(irq_cause), 32'd1);

    // Overrun: no ack, second tick with tick_pend set; clear; clear+set
    go_to(59);
    checkOutput("t5_no_overrun", 32'(overrun), 32'd0);
    go_to(60);
    checkOutput("t5_overrun", 32'(overrun), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    go_to(61);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_cleared", 32'(overrun), 32'd0);
    go_to(69);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    go_to(70);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_set_wins", 32'(overrun), 32'd1);
    checkOutput("t5_irq_held", 32'(irq), 32'd1);

    // Three-cycle glitch, then a six-cycle press
    ev_base = jump_events;
    go_to(71);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    go_to(74);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    go_to(80);
    checkOutput("t6_glitch_events", 32'(jump_events - ev_base), 32'(GLITCH_EV));
    ev_base = jump_events;
    go_to(81);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    go_to(87);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    go_to(95);
    checkOutput("t6_press_events", 32'(jump_events - ev_base), 32'd1);
    checkOutput("t7_req_irq", 32'(irq), 32'd1);

    // Reset while in REQ aborts everything and restarts the divider
    reset = 1'b1;
    @(negedge clock);
    checkOutput("t7_irq",     32'(irq), 32'd0);
    checkOutput("t7_cause",   32'(irq_cause), 32'd0);
    checkOutput("t7_fcount",  32'(frame_count), 32'd0);
    checkOutput("t7_overrun", 32'(overrun), 32'd0);
    checkOutput("t7_tickcnt", 32'(dut.tick_cnt), 32'd0);
    reset = 1'b0;
    go_to(5);
    checkOutput("t7_tickcnt_run", 32'(dut.tick_cnt), 32'd5);
    go_to(11);
    checkOutput("t7_irq_again", 32'(irq), 32'd1);
    checkOutput("t7_cause_tick", 32'(irq_cause), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
